// File: rtl/sum_result_checker.sv
// sum_result_checker: watches a bounded-accumulator producer. When its loop
// completes, it recomputes n*(n-1)/2 mod 2^W and presents the result on a
// valid/ready port.
// Optional build macro SUM_CHECK_STICKY_EN adds a sticky mismatch flag
// (err_sticky). Without the macro, err_sticky is tied to 0.
module sum_result_checker #(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_in,
    input  logic [W-1:0] n_in,
    input  logic [W-1:0] sum_in,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_sum,
    output logic [W-1:0] res_expected,
    output logic         res_match,
    output logic         busy,
    output logic         err_sticky
);

    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [2:0] {
        ST_ARMED   = 3'd0,
        ST_CONFIRM = 3'd1,
        ST_MULT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_REARM   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  cap_n_q, cap_n_d;
    logic [W-1:0]  cap_sum_q, cap_sum_d;
    logic [W:0]    acc_q, acc_d;
    logic [W:0]    mcand_q, mcand_d;
    logic [W-1:0]  mplier_q, mplier_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          res_valid_q, res_valid_d;
    logic [W-1:0]  res_sum_q, res_sum_d;
    logic [W-1:0]  res_expected_q, res_expected_d;
    logic          res_match_q, res_match_d;
    logic          busy_q, busy_d;
    logic          done_c;
    logic [W:0]    acc_next_c;
`ifdef SUM_CHECK_STICKY_EN
    logic          err_sticky_q, err_sticky_d;
`endif

    assign done_c = (i_in >= n_in);

    // Next-state, capture, shift-add multiplier and result assembly.
    always_comb begin
        state_d        = state_q;
        cap_n_d        = cap_n_q;
        cap_sum_d      = cap_sum_q;
        acc_d          = acc_q;
        mcand_d        = mcand_q;
        mplier_d       = mplier_q;
        cnt_d          = cnt_q;
        res_valid_d    = res_valid_q;
        res_sum_d      = res_sum_q;
        res_expected_d = res_expected_q;
        res_match_d    = res_match_q;
        acc_next_c     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`ifdef SUM_CHECK_STICKY_EN
        err_sticky_d   = err_sticky_q;
`endif

        case (state_q)
            ST_ARMED: begin
                if (done_c) begin
                    cap_n_d   = n_in;
                    cap_sum_d = sum_in;
                    state_d   = ST_CONFIRM;
                end
            end
            ST_CONFIRM: begin
                // A completion must be seen on two consecutive cycles with unchanged values.
                if (done_c && (n_in == cap_n_q) && (sum_in == cap_sum_q)) begin
                    acc_d    = '0;
                    mcand_d  = {1'b0, cap_n_q};
                    mplier_d = cap_n_q - W'(1);
                    cnt_d    = '0;
                    state_d  = ST_MULT;
                end else begin
                    state_d  = ST_ARMED;
                end
            end
            ST_MULT: begin
                acc_d    = acc_next_c;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    // n*(n-1) is even, so dropping bit 0 halves it exactly.
                    res_expected_d = acc_next_c[W:1];
                    res_sum_d      = cap_sum_q;
                    res_match_d    = (cap_sum_q == acc_next_c[W:1]);
                    res_valid_d    = 1'b1;
                    state_d        = ST_PRESENT;
`ifdef SUM_CHECK_STICKY_EN
                    if (cap_sum_q != acc_next_c[W:1]) begin
                        err_sticky_d = 1'b1;
                    end
`endif
                end
            end
            ST_PRESENT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_REARM;
                end
            end
            ST_REARM: begin
                // Wait for the producer to restart so a held result is not rechecked.
                if (!done_c) begin
                    state_d = ST_ARMED;
                end
            end
            default: begin
                state_d = ST_ARMED;
            end
        endcase

        busy_d = (state_d == ST_CONFIRM) || (state_d == ST_MULT);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_ARMED;
            cap_n_q        <= '0;
            cap_sum_q      <= '0;
            acc_q          <= '0;
            mcand_q        <= '0;
            mplier_q       <= '0;
            cnt_q          <= '0;
            res_valid_q    <= 1'b0;
            res_sum_q      <= '0;
            res_expected_q <= '0;
            res_match_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cap_n_q        <= cap_n_d;
            cap_sum_q      <= cap_sum_d;
            acc_q          <= acc_d;
            mcand_q        <= mcand_d;
            mplier_q       <= mplier_d;
            cnt_q          <= cnt_d;
            res_valid_q    <= res_valid_d;
            res_sum_q      <= res_sum_d;
            res_expected_q <= res_expected_d;
            res_match_q    <= res_match_d;
            busy_q         <= busy_d;
        end
    end

`ifdef SUM_CHECK_STICKY_EN
    // Sticky mismatch flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end
    assign err_sticky = err_sticky_q;
`else
    assign err_sticky = 1'b0;
`endif

    assign res_valid    = res_valid_q;
    assign res_sum      = res_sum_q;
    assign res_expected = res_expected_q;
    assign res_match    = res_match_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_sum_result_checker.sv
// Scoreboard bench for sum_result_checker: directed producer runs push
// hand-computed results, and a monitor pops and compares each presented result.
module tb_sum_result_checker;

    localparam int unsigned W = 11;
`ifdef SUM_CHECK_STICKY_EN
    localparam int STICKY_EXP = 1;
`else
    localparam int STICKY_EXP = 0;
`endif

    typedef struct packed {
        logic [W-1:0] s;
        logic [W-1:0] e;
        logic         m;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] i_in, n_in, sum_in;
    logic         res_valid, res_ready, res_match, busy, err_sticky;
    logic [W-1:0] res_sum, res_expected;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    logic seen  = 1'b0;

    sum_result_checker #(.W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_in         (i_in),
        .n_in         (n_in),
        .sum_in       (sum_in),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_sum      (res_sum),
        .res_expected (res_expected),
        .res_match    (res_match),
        .busy         (busy),
        .err_sticky   (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic drive(input int i, input int n, input int s);
        i_in   = W'(i);
        n_in   = W'(n);
        sum_in = W'(s);
    endtask

    task automatic push(input int s, input int e, input int m);
        exp_t x;
        x.s = W'(s);
        x.e = W'(e);
        x.m = 1'(m);
        sb_q.push_back(x);
    endtask

    // Count edges from the sampling edge until res_valid is seen; expect 13.
    task automatic wait_result(input string name);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!res_valid && lat < 40);
        check(name, lat, 13);
    endtask

    task automatic handshake(input string name);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check(name, int'(res_valid), 0);
    endtask

    task automatic rearm(input int n);
        drive(0, n, 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: each rising res_valid is checked against the next expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && res_valid && !seen) begin
                seen = 1'b1;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: got sum %0d expected %0d, want no result",
                             res_sum, res_expected);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("res_sum", int'(res_sum), int'(mon_e.s));
                    check("res_expected", int'(res_expected), int'(mon_e.e));
                    check("res_match", int'(res_match), int'(mon_e.m));
                end
            end else if (!res_valid) begin
                seen = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        rst       = 1'b1;
        res_ready = 1'b0;
        drive(0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_valid", int'(res_valid), 0);
        check("rst_sum", int'(res_sum), 0);
        check("rst_expected", int'(res_expected), 0);
        check("rst_match", int'(res_match), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sticky", int'(err_sticky), 0);

        // n=0 and n=1 corner cases
        rst = 1'b0;
        push(0, 0, 1);
        wait_result("lat_n0");
        handshake("hs_n0");
        drive(0, 1, 0);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1, 0);
        push(0, 0, 1);
        wait_result("lat_n1");
        handshake("hs_n1");

        // Mismatching result then a matching one; sticky flag behaviour
        rearm(10);
        drive(10, 10, 100);
        push(100, 45, 0);
        wait_result("lat_bad");
        check("sticky_set", int'(err_sticky), STICKY_EXP);
        handshake("hs_bad");
        rearm(10);
        drive(10, 10, 45);
        push(45, 45, 1);
        wait_result("lat_good");
        check("sticky_hold", int'(err_sticky), STICKY_EXP);
        handshake("hs_good");

        // Full producer run n=150, sum wraps in 11 bits
        s = 0;
        for (int k = 0; k < 150; k++) begin
            drive(k, 150, s);
            s = (s + k) & 2047;
            @(negedge clk);
        end
        drive(150, 150, s);
        push(935, 935, 1);
        wait_result("lat_150");
        handshake("hs_150");

        // Backpressure with input churn, then no re-check while still done
        rearm(20);
        drive(20, 20, 190);
        push(190, 190, 1);
        wait_result("lat_bp");
        for (int k = 0; k < 5; k++) begin
            drive(((k % 2) == 0) ? 25 : 5, 20, k * 37);
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", int'(res_valid), 1);
            check("bp_sum", int'(res_sum), 190);
            check("bp_expected", int'(res_expected), 190);
            check("bp_match", int'(res_match), 1);
        end
        handshake("hs_bp");
        drive(20, 20, 190);
        repeat (20) @(negedge clk);
        check("rearm_no_result", int'(res_valid), 0);
        check("rearm_busy", int'(busy), 0);
        check("bp_hold_sum", int'(res_sum), 190);

        // Single-cycle glitch: busy for exactly one cycle, no result
        rearm(20);
        drive(20, 20, 190);
        check("glitch_busy0", int'(busy), 0);
        @(posedge clk);
        @(negedge clk);
        check("glitch_busy1", int'(busy), 1);
        drive(20, 20, 191);
        @(posedge clk);
        @(negedge clk);
        check("glitch_busy2", int'(busy), 0);
        drive(0, 20, 0);
        repeat (20) @(negedge clk);
        check("glitch_no_result", int'(res_valid), 0);
        check("glitch_busy3", int'(busy), 0);

        // Asynchronous reset in MULT cycle 5, then a fresh full-latency run
        drive(150, 150, 935);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("mult_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", int'(res_valid), 0);
        check("arst_sum", int'(res_sum), 0);
        check("arst_expected", int'(res_expected), 0);
        check("arst_match", int'(res_match), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_sticky", int'(err_sticky), 0);
        drive(0, 150, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(150, 150, 935);
        push(935, 935, 1);
        wait_result("lat_after_rst");
        handshake("hs_after_rst");

        repeat (2) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sum_result_checker.md
Name: sum_result_checker

Overview:
- Downstream consumer of the bounded-accumulator stage, which accumulates sum += i while i < n.
- Watches the producer's i/n/sum outputs and detects loop completion.
- Recomputes the closed form n*(n-1)/2 mod 2^W with a sequential shift-add multiplier, then presents captured sum, expected value and match flag on a valid/ready result port.
- Re-arms when the producer starts a new run.

Parameters:
W, 11, datapath width of i/n/sum; all arithmetic modulo 2^W unless stated.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
i_in  input  W  producer loop counter
n_in  input  W  producer loop bound
sum_in  input  W  producer accumulator
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_sum  output  W  captured sum_in
res_expected  output  W  n*(n-1)/2 mod 2^W
res_match  output  1  res_sum == res_expected
busy  output  1  high in CONFIRM or MULT
err_sticky  output  1  see Optional Feature

Behaviour:
- Reset (async assert, sync deassert by system): state=ARMED; res_valid=0, res_sum=0, res_expected=0, res_match=0, busy=0, err_sticky=0; multiplier registers cleared.
- Done condition: i_in >= n_in (unsigned).
- ARMED: on a cycle with the done condition, capture n_in and sum_in, then go to CONFIRM.
- CONFIRM: next cycle, re-check.
  - Done condition holds and n_in/sum_in equal the captured values: go to MULT.
  - Otherwise: return to ARMED, discard the capture.
- MULT: shift-add of captured n times (n-1), in a W+1-bit accumulator (product mod 2^(W+1)).
  - One multiplier bit (LSB first) per cycle; exactly W cycles.
  - Then res_expected = product[W:1]. n*(n-1) is always even, so the shift is exact.
  - n=0: (n-1) wraps to all-ones, but the product is 0, so expected=0. n=1: expected=0.
- After the last MULT cycle:
  - res_sum = captured sum; res_match = (res_sum == res_expected).
  - res_valid=1; go to PRESENT.
- Latency: first done-sample cycle to res_valid high = W+2 cycles (13 for W=11).
- PRESENT: res_valid and all res_* held stable until res_valid && res_ready at a clock edge. Then res_valid=0 next cycle and go to REARM. res_* keep their last values after the handshake.
- REARM: wait for i_in < n_in (producer restarted), then go to ARMED. Prevents re-checking the same held result.
- Input changes during MULT/PRESENT are ignored; the check uses the captured values.
- rst mid-MULT or mid-PRESENT: immediate return to the reset state; partial product is lost; no result is emitted.
- res_ready is ignored outside PRESENT.
- busy=1 exactly in CONFIRM and MULT.

Optional Feature:
- Macro SUM_CHECK_STICKY_EN.
- Defined: err_sticky is set on the edge where res_valid rises with res_match=0. It stays 1 until rst; further results do not clear it.
- Undefined: err_sticky is a constant 0 and no register is inferred.

Test Plan:
1. Drive the producer sequence with n=150 and i 0..150 (sum wraps in 11 bits) -> res_valid 13 cycles after i reaches 150; res_sum=935, res_expected=935, res_match=1.
2. Hold i_in=0, n_in=0, sum_in=0 after reset -> result res_sum=0, res_expected=0, res_match=1. Repeat with n=1, i=1 -> same values.
3. Hold n_in=10, i_in=10, sum_in=100 -> res_expected=45, res_match=0. err_sticky=1 with SUM_CHECK_STICKY_EN; it stays 1 after a following matching run (n=10, sum=45); it is 0 without the macro.
4. Backpressure: in PRESENT, hold res_ready=0 for 5 cycles while toggling i_in/sum_in -> res_* stable; assert res_ready one cycle -> res_valid low next cycle. With i_in still >= n_in, no second result is produced until i_in < n_in is seen.
5. Glitch: i_in >= n_in for one cycle, then sum_in changes -> returns to ARMED, busy high only for that cycle, no result.
6. Assert rst in MULT cycle 5 -> all outputs 0 immediately (asynchronously). After release, a fresh n=150 run gives a correct result with the full 13-cycle latency.
